clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
- Consumes single-cycle pulses from the button debouncers (MODE and INC buttons) plus a 1 Hz enable tick.
- Maintains BCD time of day (hh:mm:ss).
- Provides a three-state set FSM so the user can adjust hours and minutes.
- Sits between the debouncers/prescaler and the 7-segment display driver, which reads the digit outputs and blink flags.

Parameters:
- MODE_12H, 0, 1 selects 12-hour format (hours 1..12 plus o_pm); 0 selects 24-hour format (hours 0..23).

Ports:
- i_clk  input  1  system clock, 12 MHz; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sec_tick  input  1  one-cycle pulse, once per second.
- i_mode_pulse  input  1  one-cycle pulse from MODE button debouncer.
- i_inc_pulse  input  1  one-cycle pulse from INC button debouncer.
- o_hr_tens  output  2  hours tens digit, BCD.
- o_hr_ones  output  4  hours ones digit, BCD.
- o_min_tens  output  3  minutes tens digit, BCD 0..5.
- o_min_ones  output  4  minutes ones digit, BCD.
- o_sec_tens  output  3  seconds tens digit, BCD 0..5.
- o_sec_ones  output  4  seconds ones digit, BCD.
- o_pm  output  1  PM flag; held 0 when MODE_12H=0.
- o_setting  output  1  high in SET_HR or SET_MIN.
- o_blink_hr  output  1  blank-request for hour digits.
- o_blink_min  output  1  blank-request for minute digits.

Behaviour:
- Reset (async assert, sync release):
  - State RUN.
  - Seconds and minutes 00.
  - Hours 00 (24H) or 12 with o_pm=0 (12H).
  - Blink phase 0; o_setting, o_blink_hr, o_blink_min all 0.
- All outputs are registered. A qualifying input at edge n is visible on the outputs after edge n.
- FSM states RUN, SET_HR, SET_MIN:
  - RUN -> SET_HR on i_mode_pulse.
  - SET_HR -> SET_MIN on i_mode_pulse.
  - SET_MIN -> RUN on i_mode_pulse.
  - Leaving SET_MIN clears seconds to 00 in the same edge.
- RUN:
  - i_sec_tick increments seconds.
  - 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours.
  - 24H: hours 23 -> 00.
  - 12H: hours 12 -> 01; 11 -> 12 toggles o_pm. At 23:59:59, a tick gives 00:00:00 (24H) or 12:00:00 AM (12H).
  - i_inc_pulse is ignored.
- SET_HR:
  - i_inc_pulse increments hours only.
  - 24H: 23 -> 00.
  - 12H: 12 -> 01, and 11 -> 12 toggles o_pm.
  - No carry into or out of minutes.
- SET_MIN:
  - i_inc_pulse increments minutes only; 59 -> 00 with no carry to hours.
- Seconds are frozen in both SET states; i_sec_tick does not advance time.
- Blink:
  - In SET states, blink phase toggles on each i_sec_tick.
  - o_blink_hr = phase & (state==SET_HR).
  - o_blink_min = phase & (state==SET_MIN).
  - Phase clears to 0 on every state change, so digits are shown immediately after entry.
  - o_setting is high while in SET_HR or SET_MIN.
- Simultaneous events in one cycle:
  - mode + inc: mode wins; inc is dropped.
  - mode + tick in RUN: the tick is applied first (time increments) and the state also moves to SET_HR.
  - inc + tick in a SET state: the inc is applied and the blink phase toggles.
- Reset mid-operation (including mid-set) returns to the reset values immediately.
- Digit registers never hold non-BCD or out-of-range values. Illegal FSM encoding recovers to RUN.

Test Plan:
1. Release reset, apply 61 ticks in RUN -> 00:01:01; o_setting=0.
2. Set hours to 23, minutes to 59 via SET states, exit (seconds cleared), then apply 60 ticks -> at 59 ticks 23:59:59; tick 60 -> 00:00:00.
3. In SET_HR with hours 22, apply 3 inc pulses -> 23, 00, 01; minutes unchanged. Apply a tick -> time does not advance and o_blink_hr toggles 0 -> 1.
4. In SET_MIN with minutes 58, apply 2 inc -> 59, then 00; hours unchanged. Assert mode and inc in the same cycle -> state RUN, minutes stay 00, seconds 00.
5. MODE_12H=1: reset -> 12:00:00 AM (o_pm=0). Set hours to 11 (11 inc from 12), then one more inc -> 12 with o_pm=1; next inc -> 01 with o_pm=1.
6. Assert i_rst_n low for 1 cycle while in SET_MIN with time 07:45 -> next observation: RUN, 00:00:00, all blink flags 0.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Pulse inputs and BCD digit / blink outputs of the time-of-day set controller.
// Inputs are single-cycle pulses; outputs are registered with no backpressure.
interface clock_set_ctrl_if;
    logic       i_sec_tick;
    logic       i_mode_pulse;
    logic       i_inc_pulse;
    logic [1:0] o_hr_tens;
    logic [3:0] o_hr_ones;
    logic [2:0] o_min_tens;
    logic [3:0] o_min_ones;
    logic [2:0] o_sec_tens;
    logic [3:0] o_sec_ones;
    logic       o_pm;
    logic       o_setting;
    logic       o_blink_hr;
    logic       o_blink_min;

    modport master (
        output i_sec_tick, i_mode_pulse, i_inc_pulse,
        input  o_hr_tens, o_hr_ones, o_min_tens, o_min_ones,
        input  o_sec_tens, o_sec_ones, o_pm, o_setting, o_blink_hr, o_blink_min
    );

    modport slave (
        input  i_sec_tick, i_mode_pulse, i_inc_pulse,
        output o_hr_tens, o_hr_ones, o_min_tens, o_min_ones,
        output o_sec_tens, o_sec_ones, o_pm, o_setting, o_blink_hr, o_blink_min
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// BCD hh:mm:ss clock with RUN/SET_HR/SET_MIN set FSM; 1-cycle latency, all outputs registered.
// No backpressure: every pulse is consumed in the cycle it arrives (mode beats inc when coincident).
module clock_set_ctrl #(
    parameter bit MODE_12H = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    clock_set_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_hr_tens;
    logic [3:0] r_hr_ones;
    logic [2:0] r_min_tens;
    logic [3:0] r_min_ones;
    logic [2:0] r_sec_tens;
    logic [3:0] r_sec_ones;
    logic       r_pm;
    logic       r_phase;
    logic       r_setting;
    logic       r_blink_hr;
    logic       r_blink_min;

    logic [1:0] w_hr_tens_inc;
    logic [3:0] w_hr_ones_inc;
    logic       w_pm_inc;
    logic [2:0] w_min_tens_inc;
    logic [3:0] w_min_ones_inc;
    logic       w_min_wrap;
    logic [2:0] w_sec_tens_inc;
    logic [3:0] w_sec_ones_inc;
    logic       w_sec_wrap;

    // Hour successor: 12H runs 12,01..11,12 with PM toggling on 11->12.
    always_comb begin
        w_hr_tens_inc = r_hr_tens;
        w_hr_ones_inc = r_hr_ones;
        w_pm_inc      = r_pm;
        if (MODE_12H) begin
            if (r_hr_tens == 2'd1 && r_hr_ones == 4'd2) begin
                w_hr_tens_inc = 2'd0;
                w_hr_ones_inc = 4'd1;
            end else if (r_hr_tens == 2'd1 && r_hr_ones == 4'd1) begin
                w_hr_ones_inc = 4'd2;
                w_pm_inc      = ~r_pm;
            end else if (r_hr_ones == 4'd9) begin
                w_hr_tens_inc = 2'd1;
                w_hr_ones_inc = 4'd0;
            end else begin
                w_hr_ones_inc = r_hr_ones + 4'd1;
            end
        end else begin
            if (r_hr_tens == 2'd2 && r_hr_ones == 4'd3) begin
                w_hr_tens_inc = 2'd0;
                w_hr_ones_inc = 4'd0;
            end else if (r_hr_ones == 4'd9) begin
                w_hr_tens_inc = r_hr_tens + 2'd1;
                w_hr_ones_inc = 4'd0;
            end else begin
                w_hr_ones_inc = r_hr_ones + 4'd1;
            end
        end
    end

    always_comb begin
        w_min_wrap     = (r_min_tens == 3'd5) && (r_min_ones == 4'd9);
        w_min_ones_inc = (r_min_ones == 4'd9) ? 4'd0 : r_min_ones + 4'd1;
        w_min_tens_inc = r_min_tens;
        if (r_min_ones == 4'd9)
            w_min_tens_inc = (r_min_tens == 3'd5) ? 3'd0 : r_min_tens + 3'd1;

        w_sec_wrap     = (r_sec_tens == 3'd5) && (r_sec_ones == 4'd9);
        w_sec_ones_inc = (r_sec_ones == 4'd9) ? 4'd0 : r_sec_ones + 4'd1;
        w_sec_tens_inc = r_sec_tens;
        if (r_sec_ones == 4'd9)
            w_sec_tens_inc = (r_sec_tens == 3'd5) ? 3'd0 : r_sec_tens + 3'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_hr_tens   <= MODE_12H ? 2'd1 : 2'd0;
            r_hr_ones   <= MODE_12H ? 4'd2 : 4'd0;
            r_min_tens  <= 3'd0;
            r_min_ones  <= 4'd0;
            r_sec_tens  <= 3'd0;
            r_sec_ones  <= 4'd0;
            r_pm        <= 1'b0;
            r_phase     <= 1'b0;
            r_setting   <= 1'b0;
            r_blink_hr  <= 1'b0;
            r_blink_min <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.i_sec_tick) begin
                        r_sec_tens <= w_sec_tens_inc;
                        r_sec_ones <= w_sec_ones_inc;
                        if (w_sec_wrap) begin
                            r_min_tens <= w_min_tens_inc;
                            r_min_ones <= w_min_ones_inc;
                            if (w_min_wrap) begin
                                r_hr_tens <= w_hr_tens_inc;
                                r_hr_ones <= w_hr_ones_inc;
                                r_pm      <= w_pm_inc;
                            end
                        end
                    end
                    if (bus.i_mode_pulse) begin
                        r_state     <= ST_SET_HR;
                        r_phase     <= 1'b0;
                        r_setting   <= 1'b1;
                        r_blink_hr  <= 1'b0;
                        r_blink_min <= 1'b0;
                    end
                end
                ST_SET_HR: begin
                    if (bus.i_mode_pulse) begin
                        r_state     <= ST_SET_MIN;
                        r_phase     <= 1'b0;
                        r_setting   <= 1'b1;
                        r_blink_hr  <= 1'b0;
                        r_blink_min <= 1'b0;
                    end else begin
                        if (bus.i_inc_pulse) begin
                            r_hr_tens <= w_hr_tens_inc;
                            r_hr_ones <= w_hr_ones_inc;
                            r_pm      <= w_pm_inc;
                        end
                        if (bus.i_sec_tick) begin
                            r_phase    <= ~r_phase;
                            r_blink_hr <= ~r_phase;
                        end
                    end
                end
                ST_SET_MIN: begin
                    if (bus.i_mode_pulse) begin
                        // Leaving the set sequence restarts the minute cleanly.
                        r_state     <= ST_RUN;
                        r_sec_tens  <= 3'd0;
                        r_sec_ones  <= 4'd0;
                        r_phase     <= 1'b0;
                        r_setting   <= 1'b0;
                        r_blink_hr  <= 1'b0;
                        r_blink_min <= 1'b0;
                    end else begin
                        if (bus.i_inc_pulse) begin
                            r_min_tens <= w_min_tens_inc;
                            r_min_ones <= w_min_ones_inc;
                        end
                        if (bus.i_sec_tick) begin
                            r_phase     <= ~r_phase;
                            r_blink_min <= ~r_phase;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_phase     <= 1'b0;
                    r_setting   <= 1'b0;
                    r_blink_hr  <= 1'b0;
                    r_blink_min <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_hr_tens   = r_hr_tens;
    assign bus.o_hr_ones   = r_hr_ones;
    assign bus.o_min_tens  = r_min_tens;
    assign bus.o_min_ones  = r_min_ones;
    assign bus.o_sec_tens  = r_sec_tens;
    assign bus.o_sec_ones  = r_sec_ones;
    assign bus.o_pm        = r_pm;
    assign bus.o_setting   = r_setting;
    assign bus.o_blink_hr  = r_blink_hr;
    assign bus.o_blink_min = r_blink_min;
endmodule
